// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit for the execute stage. It runs MULT, MULTU,
// DIV and DIVU over 32 cycles and leaves the 64-bit result in HI/LO.
//   - Multiply uses radix-2 shift-add.
//   - Divide uses restoring division, one quotient bit per cycle.
// Signed operations are done on operand magnitudes. The signs are corrected
// once, in FIXUP.
//
// Configuration macro: MDU_DIV_EN
//   defined   : the divide datapath is built.
//   undefined : no divide datapath. DIV/DIVU complete in one cycle with
//               hi=0, lo=0 and div_by_zero=1.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   launch request
//   op[1:0]      in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a[W-1:0]     in   multiplicand / dividend (sampled at accept only)
//   b[W-1:0]     in   multiplier / divisor    (sampled at accept only)
//   busy         out  operation in flight
//   done         out  one-cycle pulse; hi/lo updated on this cycle
//   hi[W-1:0]    out  product high half / remainder
//   lo[W-1:0]    out  product low half / quotient
//   div_by_zero  out  last divide had b==0; cleared at the next accept
//   state_dbg    out  current FSM state (IDLE=0, CALC=1, FIXUP=2)
//
// Handshake: start is a request and ~busy is the ready. A transfer happens on
// a rising edge where start=1 and busy=0. start with busy=1 has no effect.
// Because busy is already low in the done cycle, a back-to-back start there
// is accepted.
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic               neg_lo_q;  // negate product / quotient
  logic               dz_q;      // result already sits in acc_q verbatim
  logic [WIDTH-1:0]   opnd_q;    // |multiplicand| or |divisor|
  // Multiply: acc_q = {partial sum, remaining multiplier bits}.
  // Divide:   acc_q = {partial remainder, dividend/quotient shift register}.
  logic [2*WIDTH-1:0] acc_q;

`ifdef MDU_DIV_EN
  logic               is_div_q;
  logic               neg_hi_q;  // negate remainder (sign of dividend)
`endif

  // Operand magnitudes. op[0]=0 selects the signed variants.
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  // -(-2^31) is 0x80000000, which is the correct unsigned magnitude.
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // One multiply iteration: conditionally add, then shift right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
  end

`ifdef MDU_DIV_EN
  // One restoring-divide iteration. The partial remainder is always below the
  // divisor, so the shifted value fits in WIDTH+1 bits. The difference's MSB
  // then acts as the borrow.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_step;

  always_comb begin
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_diff[WIDTH]) begin
      div_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end
`endif

  // Sign correction applied in FIXUP.
  logic [2*WIDTH-1:0] fix_res;
  logic [2*WIDTH-1:0] prod_fix;

`ifdef MDU_DIV_EN
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
`endif

  always_comb begin
    prod_fix = neg_lo_q ? -acc_q : acc_q;
`ifdef MDU_DIV_EN
    quo_fix = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (dz_q) begin
      fix_res = acc_q;
    end else if (is_div_q) begin
      fix_res = {rem_fix, quo_fix};
    end else begin
      fix_res = prod_fix;
    end
`else
    fix_res = dz_q ? acc_q : prod_fix;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      neg_lo_q    <= 1'b0;
      dz_q        <= 1'b0;
      opnd_q      <= '0;
      acc_q       <= '0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            neg_lo_q    <= a_neg ^ b_neg;
            count       <= CW'(WIDTH - 1);
            if (op[1]) begin
`ifdef MDU_DIV_EN
              is_div_q <= 1'b1;
              neg_hi_q <= a_neg;
              opnd_q   <= b_mag;
              if (b == '0) begin
                // The result is written verbatim: hi=a, lo=all-ones.
                dz_q  <= 1'b1;
                acc_q <= {a, {WIDTH{1'b1}}};
                state <= S_FIXUP;
              end else begin
                dz_q  <= 1'b0;
                acc_q <= {{WIDTH{1'b0}}, a_mag};
                state <= S_CALC;
              end
`else
              dz_q  <= 1'b1;
              acc_q <= '0;
              state <= S_FIXUP;
`endif
            end else begin
`ifdef MDU_DIV_EN
              is_div_q <= 1'b0;
`endif
              dz_q   <= 1'b0;
              opnd_q <= a_mag;
              acc_q  <= {{WIDTH{1'b0}}, b_mag};
              state  <= S_CALC;
            end
          end
        end

        S_CALC: begin
`ifdef MDU_DIV_EN
          acc_q <= is_div_q ? div_step : mul_step;
`else
          acc_q <= mul_step;
`endif
          count <= count - 1'b1;
          if (count == '0) begin
            state <= S_FIXUP;
          end
        end

        S_FIXUP: begin
          hi          <= fix_res[2*WIDTH-1:WIDTH];
          lo          <= fix_res[WIDTH-1:0];
          div_by_zero <= dz_q;
          done        <= 1'b1;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule
